// File: rtl/uart_rx_controller.sv
// Receive-side UART sequencer: oversamples the line, splits the frame into fields for the
// error checker, and captures byte plus checker verdict into a valid/ready output register.
module uart_rx_controller #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       rx_in,
  input  logic [1:0] parity_type,
  input  logic [2:0] error_flag,
  output logic [7:0] raw_data,
  output logic       parity_bit,
  output logic       start_bit,
  output logic       stop_bit,
  output logic       recieved_flag,
  output logic [7:0] rx_data,
  output logic [2:0] rx_error,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam logic [CntW-1:0] TickFull = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] TickHalf = CntW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StCheck} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      par_type_q, par_type_d;
  logic [7:0]      raw_q, raw_d;
  logic            parity_bit_q, parity_bit_d;
  logic            start_bit_q, start_bit_d;
  logic            stop_bit_q, stop_bit_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [2:0]      rx_error_q, rx_error_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    par_type_d   = par_type_q;
    raw_d        = raw_q;
    parity_bit_d = parity_bit_q;
    start_bit_d  = start_bit_q;
    stop_bit_d   = stop_bit_q;
    rx_data_d    = rx_data_q;
    rx_error_d   = rx_error_q;
    rx_valid_d   = rx_valid_q;
    overrun_d    = overrun_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (baud_tick && !rx_in) begin
          state_d    = StStart;
          tick_d     = '0;
          par_type_d = parity_type;
        end
      end
      StStart: begin
        if (baud_tick) begin
          if (tick_q == TickHalf) begin
            start_bit_d = rx_in;
            if (rx_in) begin
              state_d = StIdle;
            end else begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = StData;
            end
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StData: begin
        if (baud_tick) begin
          if (tick_q == TickFull) begin
            tick_d       = '0;
            raw_d[bit_q] = rx_in;
            if (bit_q == 3'd7) begin
              if (par_type_q == 2'b01 || par_type_q == 2'b10) begin
                state_d = StParity;
              end else begin
                parity_bit_d = 1'b1;
                state_d      = StStop;
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          if (tick_q == TickFull) begin
            tick_d       = '0;
            parity_bit_d = rx_in;
            state_d      = StStop;
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StStop: begin
        if (baud_tick) begin
          if (tick_q == TickFull) begin
            tick_d     = '0;
            stop_bit_d = rx_in;
            state_d    = StCheck;
          end else begin
            tick_d = tick_q + CntW'(1);
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        // Load only into an empty or just-drained register; otherwise drop and flag.
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = raw_q;
          rx_error_d = error_flag;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      tick_q       <= '0;
      bit_q        <= '0;
      par_type_q   <= '0;
      raw_q        <= '0;
      parity_bit_q <= 1'b1;
      start_bit_q  <= 1'b0;
      stop_bit_q   <= 1'b1;
      rx_data_q    <= '0;
      rx_error_q   <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      par_type_q   <= par_type_d;
      raw_q        <= raw_d;
      parity_bit_q <= parity_bit_d;
      start_bit_q  <= start_bit_d;
      stop_bit_q   <= stop_bit_d;
      rx_data_q    <= rx_data_d;
      rx_error_q   <= rx_error_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign raw_data      = raw_q;
  assign parity_bit    = parity_bit_q;
  assign start_bit     = start_bit_q;
  assign stop_bit      = stop_bit_q;
  assign recieved_flag = (state_q == StCheck);
  assign rx_data       = rx_data_q;
  assign rx_error      = rx_error_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: hand-built frames with hand-computed fields/verdicts.
module tb_uart_rx_controller;

  localparam int unsigned Os = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic [2:0] error_flag;
  logic [7:0] raw_data;
  logic       parity_bit;
  logic       start_bit;
  logic       stop_bit;
  logic       recieved_flag;
  logic [7:0] rx_data;
  logic [2:0] rx_error;
  logic       rx_valid;
  logic       rx_ready;
  logic       overrun;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;
  int strobes = 0;
  int strobes_before;

  uart_rx_controller #(.OVERSAMPLE(Os)) dut (
    .clock        (clock),
    .reset        (reset),
    .baud_tick    (baud_tick),
    .rx_in        (rx_in),
    .parity_type  (parity_type),
    .error_flag   (error_flag),
    .raw_data     (raw_data),
    .parity_bit   (parity_bit),
    .start_bit    (start_bit),
    .stop_bit     (stop_bit),
    .recieved_flag(recieved_flag),
    .rx_data      (rx_data),
    .rx_error     (rx_error),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (recieved_flag) strobes <= strobes + 1;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_in = b;
    cycles(Os);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic has_par, input logic par,
                            input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (has_par) drive_bit(par);
    drive_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    cycles(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; baud_tick = 1'b1; rx_in = 1'b1; parity_type = 2'b00;
    error_flag = 3'b000; rx_ready = 1'b0;
    cycles(3);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_raw", raw_data, 8'h00);
    check_eq("rst_par", parity_bit, 1);
    check_eq("rst_stop", stop_bit, 1);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_flag", recieved_flag, 0);
    cycles(2);

    // 1: even parity, A5 (four ones -> parity 0)
    parity_type = 2'b10; error_flag = 3'b000; strobes_before = strobes;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    cycles(20);
    @(negedge clock);
    check_eq("t1_strobes", 8'(strobes - strobes_before), 1);
    check_eq("t1_data", rx_data, 8'hA5);
    check_eq("t1_err", rx_error, 0);
    check_eq("t1_valid", rx_valid, 1);
    check_eq("t1_raw", raw_data, 8'hA5);
    check_eq("t1_par", parity_bit, 0);
    check_eq("t1_start", start_bit, 0);
    check_eq("t1_busy", busy, 0);
    accept();
    @(negedge clock);
    check_eq("t1_drained", rx_valid, 0);
    check_eq("t1_hold", rx_data, 8'hA5);

    // 2: odd parity, 3C with parity 0 -> parity error from checker
    parity_type = 2'b01; error_flag = 3'b001;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    parity_type = 2'b00;
    cycles(20);
    @(negedge clock);
    check_eq("t2_raw", raw_data, 8'h3C);
    check_eq("t2_par", parity_bit, 0);
    check_eq("t2_err", rx_error, 3'b001);
    check_eq("t2_data", rx_data, 8'h3C);
    accept();

    // 3: no parity, 55 with bad stop, then 0F clean
    parity_type = 2'b00; error_flag = 3'b100;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    cycles(20);
    @(negedge clock);
    check_eq("t3_par", parity_bit, 1);
    check_eq("t3_stop", stop_bit, 0);
    check_eq("t3_err", rx_error, 3'b100);
    check_eq("t3_data", rx_data, 8'h55);
    accept();
    error_flag = 3'b000;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    cycles(20);
    @(negedge clock);
    check_eq("t3b_data", rx_data, 8'h0F);
    check_eq("t3b_err", rx_error, 0);
    check_eq("t3b_stop", stop_bit, 1);
    accept();

    // 4: 4-tick glitch rejected
    strobes_before = strobes;
    rx_in = 1'b0;
    cycles(2);
    @(negedge clock);
    check_eq("t4_busy_hi", busy, 1);
    cycles(2);
    rx_in = 1'b1;
    cycles(8);
    @(negedge clock);
    check_eq("t4_busy_lo", busy, 0);
    check_eq("t4_strobes", 8'(strobes - strobes_before), 0);
    check_eq("t4_valid", rx_valid, 0);

    // 5: two frames with no consumer -> overrun, first byte kept
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    cycles(20);
    @(negedge clock);
    check_eq("t5_ovr_pre", overrun, 0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    cycles(20);
    @(negedge clock);
    check_eq("t5_data", rx_data, 8'h11);
    check_eq("t5_ovr", overrun, 1);
    check_eq("t5_valid", rx_valid, 1);
    accept();
    @(negedge clock);
    check_eq("t5_drained", rx_valid, 0);
    check_eq("t5_ovr_sticky", overrun, 1);

    // 6: reset during data bit 4 of 7E, then a clean 7E even parity frame
    parity_type = 2'b10; strobes_before = strobes;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b0 : 1'b1);
    rx_in = 1'b1;
    cycles(8);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    @(negedge clock);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_raw", raw_data, 8'h00);
    check_eq("t6_par", parity_bit, 1);
    check_eq("t6_stop", stop_bit, 1);
    check_eq("t6_ovr", overrun, 0);
    check_eq("t6_data", rx_data, 8'h00);
    check_eq("t6_strobes", 8'(strobes - strobes_before), 0);
    cycles(5);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b1);
    cycles(20);
    @(negedge clock);
    check_eq("t6b_data", rx_data, 8'h7E);
    check_eq("t6b_err", rx_error, 0);
    check_eq("t6b_valid", rx_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
